// File: rtl/calc_sequencer.sv
// calc_sequencer: top-level control FSM for the four-digit signed calculator.
// Owns the accumulator, steers the datapath via mode/operation, and commits
// the datapath result one cycle after an ENTRY confirm.
// Optional build macro: CALC_ERR_TIMEOUT_EN adds automatic recovery from
// ERROR after ERR_HOLD_CYCLES cycles.
module calc_sequencer #(
    parameter int ERR_HOLD_CYCLES = 100_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               UP,
    input  logic               DOWN,
    input  logic               LEFT,
    input  logic               RIGHT,
    input  logic               SELECT,
    input  logic signed [15:0] new_value,
    input  logic               overflow,
    output logic        [1:0]  mode,
    output logic        [1:0]  operation,
    output logic signed [15:0] current_value,
    output logic               result_valid,
    output logic               error,
    output logic        [7:0]  op_count
);

    // State encoding is the mode output itself.
    typedef enum logic [1:0] {
        S_OP_SEL  = 2'd0,
        S_ENTRY   = 2'd1,
        S_CAPTURE = 2'd2,
        S_ERROR   = 2'd3
    } state_t;

    localparam logic signed [15:0] VAL_MAX = 16'sd9999;
    localparam logic signed [15:0] VAL_MIN = -16'sd9999;

    state_t state;
    logic   result_ok;

    // LEFT/RIGHT only matter to the datapath's digit editor.
    logic unused_buttons;
    assign unused_buttons = LEFT ^ RIGHT;

    // A result is committed only if the datapath reports no overflow and the
    // value still fits the four-digit display range.
    assign result_ok = !overflow && (new_value <= VAL_MAX) && (new_value >= VAL_MIN);

`ifdef CALC_ERR_TIMEOUT_EN
    localparam int TW = (ERR_HOLD_CYCLES > 1) ? $clog2(ERR_HOLD_CYCLES) : 1;
    logic [TW-1:0] err_timer;
    logic          timeout;
    // Last cycle of the hold window: recover on this edge.
    assign timeout = (err_timer == TW'(ERR_HOLD_CYCLES - 1));
`else
    localparam int unused_hold = ERR_HOLD_CYCLES;
    logic timeout;
    assign timeout = 1'b0;
`endif

    assign mode = state;

    // Main sequencer: state, operation select, accumulator and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_OP_SEL;
            operation     <= 2'd0;
            current_value <= '0;
            result_valid  <= 1'b0;
            error         <= 1'b0;
            op_count      <= 8'd0;
`ifdef CALC_ERR_TIMEOUT_EN
            err_timer     <= '0;
`endif
        end else begin
            result_valid <= 1'b0;
            case (state)
                S_OP_SEL: begin
                    if (SELECT)    state     <= S_ENTRY;
                    else if (UP)   operation <= operation + 2'd1;
                    else if (DOWN) operation <= operation - 2'd1;
                end
                S_ENTRY: begin
                    // Datapath computes on this same edge; sample it next cycle.
                    if (SELECT) state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (result_ok) begin
                        current_value <= new_value;
                        result_valid  <= 1'b1;
                        op_count      <= op_count + 8'd1;
                        state         <= S_OP_SEL;
                    end else begin
                        state <= S_ERROR;
                        error <= 1'b1;
`ifdef CALC_ERR_TIMEOUT_EN
                        err_timer <= '0;
`endif
                    end
                end
                S_ERROR: begin
                    if (SELECT || timeout) begin
                        current_value <= '0;
                        operation     <= 2'd0;
                        error         <= 1'b0;
                        state         <= S_OP_SEL;
`ifdef CALC_ERR_TIMEOUT_EN
                        err_timer     <= '0;
`endif
                    end else begin
`ifdef CALC_ERR_TIMEOUT_EN
                        err_timer <= err_timer + 1'b1;
`endif
                    end
                end
                default: state <= S_OP_SEL;
            endcase
        end
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Top-level control FSM for the four-digit signed integer calculator. It owns the accumulator (`current_value`), drives the `mode` and `operation` selects into the operand-entry/arithmetic datapath, and captures that datapath's `new_value`/`overflow` one cycle after a confirm. It sits between the debounced button pulses and the datapath and display, and sequences operation selection, operand entry, commit and error recovery.

## Interface
Parameters:
- `ERR_HOLD_CYCLES`, default 100_000_000: cycles the ERROR state is held before automatic recovery. Used only with `CALC_ERR_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `UP`, `DOWN`, `LEFT`, `RIGHT`, `SELECT`  in  1 each  debounced, single-cycle button pulses.
- `new_value`  in  16 signed  datapath result, valid the cycle after a confirm.
- `overflow`  in  1  datapath overflow / divide-by-zero flag, valid the cycle after a confirm.
- `mode`  out  2  0 = OP_SEL, 1 = ENTRY, 2 = CAPTURE, 3 = ERROR.
- `operation`  out  2  0 = add, 1 = sub, 2 = mul, 3 = div.
- `current_value`  out  16 signed  accumulator, range -9999..9999.
- `result_valid`  out  1  one-cycle pulse on each successful commit.
- `error`  out  1  high while in ERROR.
- `op_count`  out  8  committed-operation counter; wraps 255 -> 0.

## Operation
- States are encoded directly on `mode`.
- **OP_SEL (0)**
  - `UP`: `operation` + 1, wrapping 3 -> 0.
  - `DOWN`: `operation` - 1, wrapping 0 -> 3.
  - `SELECT`: go to ENTRY. `operation` is frozen until the next OP_SEL.
  - `LEFT`/`RIGHT`: ignored.
- **ENTRY (1)**
  - `UP`/`DOWN`/`LEFT`/`RIGHT`: ignored here; the datapath consumes them to edit digits.
  - `SELECT`: go to CAPTURE. The datapath computes on this same edge.
- **CAPTURE (2)**: lasts exactly one cycle; all buttons are ignored.
  - On its closing edge with `overflow`=0: `current_value` <= `new_value`; `result_valid` pulses for the next cycle; `op_count` increments; go to OP_SEL.
  - With `overflow`=1: `current_value` is unchanged; go to ERROR.
- **ERROR (3)**
  - `SELECT`: `current_value` <= 0, `operation` <= 0, go to OP_SEL.
  - All other buttons are ignored.
- **Simultaneous buttons**: priority is `SELECT` > `UP` > `DOWN`. Only the highest-priority button in a cycle acts.
- The first operand is entered as 0 plus the operand (add is the default), which loads the accumulator.
- **Defensive range check**: a `new_value` outside -9999..9999 with `overflow`=0 is treated as overflow and goes to ERROR.

## Timing
- **Reset values**: `mode`=0, `operation`=0, `current_value`=0, `result_valid`=0, `error`=0, `op_count`=0, error timer=0.
- Reset has priority over every button and over the CAPTURE sampling. If `rst` is asserted during CAPTURE, the result is discarded.
- **Latency**:
  - ENTRY `SELECT` at edge N -> CAPTURE during N..N+1.
  - `new_value`/`overflow` are sampled at edge N+1.
  - `current_value`, `result_valid` and `mode`=0 are visible after N+1.
- **Contract with the datapath**: the datapath clears `overflow` whenever its confirm is not asserted. Overflow is therefore valid only in the single CAPTURE cycle, and the controller must sample it there and nowhere else.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `op_count` increments only on a successful commit, never on entry to ERROR.

## Configuration
- Macro: `CALC_ERR_TIMEOUT_EN`.
- **Defined**:
  - A counter runs while in ERROR.
  - After `ERR_HOLD_CYCLES` cycles in ERROR it performs the same recovery as `SELECT`.
  - `SELECT` still recovers immediately and resets the counter.
  - The counter is cleared on ERROR entry and on reset.
- **Undefined**: the counter is not built; ERROR is left only by `SELECT` or `rst`.

## Test plan
- Reset mid-state: enter ENTRY, assert `rst` -> all outputs at reset values next cycle.
- Operation wrap: from `operation`=0 pulse `DOWN` -> 3; pulse `UP` twice -> 1. `LEFT` in OP_SEL -> no change.
- Commit: OP_SEL `SELECT`, ENTRY `SELECT`, drive `new_value`=1234, `overflow`=0 in CAPTURE -> `current_value`=1234, one `result_valid` pulse, `op_count`=1, `mode`=0.
- Overflow: `current_value`=1234, drive `overflow`=1 in CAPTURE -> `mode`=3, `error`=1, `current_value` stays 1234, `op_count` unchanged. `SELECT` -> `current_value`=0, `mode`=0.
- Priority: `SELECT`+`UP` in the same OP_SEL cycle -> ENTRY, `operation` unchanged. `UP` during CAPTURE -> ignored.
- With `CALC_ERR_TIMEOUT_EN` and `ERR_HOLD_CYCLES`=8: enter ERROR, no buttons -> `mode`=0 and `current_value`=0 exactly 8 cycles after ERROR entry.
